hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a 5-stage in-order core. It detects load-use
// hazards, squashes wrong-path instructions after a taken branch, freezes the
// pipe while a memory access is outstanding (with a timeout watchdog), and
// selects operand forwarding sources for the instruction in ID.
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   id_ra_addr_i / id_rb_addr_i       source register addresses in ID
//   id_uses_ra_i / id_uses_rb_i       source actually read by ID instruction
//   ex_rd_addr_i                      destination of instruction in EX
//   ex_is_load_i / ex_writes_rd_i     EX instruction is a load / writes rd
//   ex_branch_taken_i                 EX resolved a taken branch or jump
//   mem_req_i / mem_ack_i             MEM access issued / completed
//   if_stall_o / id_stall_o           hold IF/ID registers
//   id_ex_valid_o                     0 loads a NOP bubble into ID/EX
//   if_id_flush_o                     replace IF/ID contents with NOP
//   ex_mem_hold_o                     freeze EX/MEM and earlier stages
//   fwd_a_sel_o / fwd_b_sel_o         0=regfile, 1=MEM result, 2=WB result
//   timeout_err_o                     sticky memory timeout flag
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int BR_PENALTY  = 2,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_ra_addr_i,
    input  logic [REG_AW-1:0] id_rb_addr_i,
    input  logic              id_uses_ra_i,
    input  logic              id_uses_rb_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_is_load_i,
    input  logic              ex_writes_rd_i,
    input  logic              ex_branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              if_stall_o,
    output logic              id_stall_o,
    output logic              id_ex_valid_o,
    output logic              if_id_flush_o,
    output logic              ex_mem_hold_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              timeout_err_o
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_BR_FLUSH   = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_t;

    // Flush counter is loaded with the number of flush cycles still to come
    // after the cycle in which the branch resolves.
    localparam logic [2:0] BR_RELOAD = 3'(BR_PENALTY - 1);
    localparam logic [8:0] TMO_LIMIT = 9'(MEM_TIMEOUT);
    localparam logic [REG_AW-1:0] REG_X0 = {REG_AW{1'b0}};

    // True when a non-x0 destination matches a source address.
    function automatic logic addr_hit(input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] src);
        return (rd == src) && (rd != REG_X0);
    endfunction

    // Forwarding source for one operand; the younger MEM entry wins, and a
    // load still in MEM has no data yet so it is never forwarded from there.
    function automatic logic [1:0] fwd_pick(input logic [REG_AW-1:0] src,
                                            input logic [REG_AW-1:0] m_rd,
                                            input logic              m_wr,
                                            input logic              m_ld,
                                            input logic [REG_AW-1:0] w_rd,
                                            input logic              w_wr);
        logic [1:0] sel;
        if (m_wr && !m_ld && addr_hit(m_rd, src)) begin
            sel = 2'd1;
        end else if (w_wr && addr_hit(w_rd, src)) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    state_t      state_q, state_d;
    state_t      saved_q, saved_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    // Destination tracker: whether the instruction now in EX is real, and the
    // MEM / WB copies of {rd, writes_rd, is_load}.
    logic              ex_valid_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              mem_wr_q;
    logic              mem_ld_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic              wb_wr_q;

    logic       mem_wait_s;
    logic       load_use_s;
    logic       branch_s;
    logic [8:0] tmo_inc_s;

    assign mem_wait_s = mem_req_i & ~mem_ack_i;
    assign branch_s   = ex_branch_taken_i;
    assign tmo_inc_s  = {1'b0, tmo_cnt_q} + 9'd1;
    assign load_use_s = ex_is_load_i && (ex_rd_addr_i != REG_X0) &&
                        ((id_uses_ra_i && (id_ra_addr_i == ex_rd_addr_i)) ||
                         (id_uses_rb_i && (id_rb_addr_i == ex_rd_addr_i)));

    // State register, counters and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            saved_q       <= ST_RUN;
            flush_cnt_q   <= 3'd0;
            tmo_cnt_q     <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            saved_q       <= saved_d;
            flush_cnt_q   <= flush_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic; priority is mem wait, then branch, then load-use
    always_comb begin
        state_d       = state_q;
        saved_d       = saved_q;
        flush_cnt_d   = flush_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_RUN, ST_LOAD_STALL: begin
                if (mem_wait_s) begin
                    state_d   = ST_MEM_WAIT;
                    saved_d   = state_q;
                    tmo_cnt_d = 8'd0;
                end else if (branch_s) begin
                    flush_cnt_d = BR_RELOAD;
                    state_d     = (BR_PENALTY > 1) ? ST_BR_FLUSH : ST_RUN;
                end else if ((state_q == ST_RUN) && load_use_s) begin
                    state_d = ST_LOAD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_BR_FLUSH: begin
                if (mem_wait_s) begin
                    // Flush counter is left untouched, so it survives the wait.
                    state_d   = ST_MEM_WAIT;
                    saved_d   = ST_BR_FLUSH;
                    tmo_cnt_d = 8'd0;
                end else if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_d   = saved_q;
                    tmo_cnt_d = 8'd0;
                end else if (tmo_inc_s >= TMO_LIMIT) begin
                    timeout_err_d = 1'b1;
                    state_d       = saved_q;
                    tmo_cnt_d     = 8'd0;
                end else begin
                    tmo_cnt_d = tmo_inc_s[7:0];
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output decode from state and same-cycle events
    always_comb begin
        if_stall_o    = 1'b0;
        id_stall_o    = 1'b0;
        id_ex_valid_o = 1'b1;
        if_id_flush_o = 1'b0;
        ex_mem_hold_o = 1'b0;
        fwd_a_sel_o   = 2'd0;
        fwd_b_sel_o   = 2'd0;
        timeout_err_o = 1'b0;
        if (!rst_n) begin
            // Reset presents plain RUN behaviour regardless of stored state.
            ex_mem_hold_o = 1'b0;
        end else begin
            timeout_err_o = timeout_err_q;
            fwd_a_sel_o   = fwd_pick(id_ra_addr_i, mem_rd_q, mem_wr_q, mem_ld_q,
                                     wb_rd_q, wb_wr_q);
            fwd_b_sel_o   = fwd_pick(id_rb_addr_i, mem_rd_q, mem_wr_q, mem_ld_q,
                                     wb_rd_q, wb_wr_q);
            case (state_q)
                ST_RUN, ST_LOAD_STALL: begin
                    if (mem_wait_s) begin
                        if_stall_o    = 1'b1;
                        id_stall_o    = 1'b1;
                        ex_mem_hold_o = 1'b1;
                    end else if (branch_s) begin
                        if_id_flush_o = 1'b1;
                        id_ex_valid_o = 1'b0;
                    end else if ((state_q == ST_RUN) && load_use_s) begin
                        if_stall_o    = 1'b1;
                        id_stall_o    = 1'b1;
                        id_ex_valid_o = 1'b0;
                    end else begin
                        id_ex_valid_o = 1'b1;
                    end
                end
                ST_BR_FLUSH: begin
                    if (mem_wait_s) begin
                        if_stall_o    = 1'b1;
                        id_stall_o    = 1'b1;
                        ex_mem_hold_o = 1'b1;
                    end else begin
                        if_id_flush_o = 1'b1;
                        id_ex_valid_o = 1'b0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ack_i) begin
                        if_stall_o    = 1'b1;
                        id_stall_o    = 1'b1;
                        ex_mem_hold_o = 1'b1;
                    end else if (saved_q == ST_BR_FLUSH) begin
                        // The pipe moves on the ack cycle; keep squashing so no
                        // wrong-path fetch slips in before the flush resumes.
                        if_id_flush_o = 1'b1;
                        id_ex_valid_o = 1'b0;
                    end else begin
                        id_ex_valid_o = 1'b1;
                    end
                end
                default: begin
                    id_ex_valid_o = 1'b1;
                end
            endcase
        end
    end

    // Destination tracker shift; frozen together with EX/MEM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            mem_rd_q   <= {REG_AW{1'b0}};
            mem_wr_q   <= 1'b0;
            mem_ld_q   <= 1'b0;
            wb_rd_q    <= {REG_AW{1'b0}};
            wb_wr_q    <= 1'b0;
        end else if (!ex_mem_hold_o) begin
            ex_valid_q <= id_ex_valid_o;
            mem_rd_q   <= ex_rd_addr_i;
            mem_wr_q   <= ex_writes_rd_i & ex_valid_q;
            mem_ld_q   <= ex_is_load_i & ex_valid_q;
            wb_rd_q    <= mem_rd_q;
            wb_wr_q    <= mem_wr_q;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed-vector bench for hazard_ctrl with default parameters. Inputs are
// applied just after the falling edge and outputs are checked 1 ns later, so
// each drv/check group describes one clock cycle.
// Control bundle order: {if_stall, id_stall, id_ex_valid, if_id_flush, ex_mem_hold}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [4:0] C_RUN = 5'b00100;
    localparam logic [4:0] C_LU  = 5'b11000;
    localparam logic [4:0] C_BR  = 5'b00010;
    localparam logic [4:0] C_MW  = 5'b11101;

    logic       clk;
    logic       rst_n;
    logic       rst_v;
    logic [4:0] id_ra_addr, id_rb_addr, ex_rd_addr;
    logic       id_uses_ra, id_uses_rb, ex_is_load, ex_writes_rd;
    logic       ex_branch_taken, mem_req, mem_ack;
    logic       if_stall, id_stall, id_ex_valid, if_id_flush, ex_mem_hold;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       timeout_err;
    logic [4:0] ctl;

    int tests_run;
    int tests_failed;

    hazard_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_ra_addr_i      (id_ra_addr),
        .id_rb_addr_i      (id_rb_addr),
        .id_uses_ra_i      (id_uses_ra),
        .id_uses_rb_i      (id_uses_rb),
        .ex_rd_addr_i      (ex_rd_addr),
        .ex_is_load_i      (ex_is_load),
        .ex_writes_rd_i    (ex_writes_rd),
        .ex_branch_taken_i (ex_branch_taken),
        .mem_req_i         (mem_req),
        .mem_ack_i         (mem_ack),
        .if_stall_o        (if_stall),
        .id_stall_o        (id_stall),
        .id_ex_valid_o     (id_ex_valid),
        .if_id_flush_o     (if_id_flush),
        .ex_mem_hold_o     (ex_mem_hold),
        .fwd_a_sel_o       (fwd_a_sel),
        .fwd_b_sel_o       (fwd_b_sel),
        .timeout_err_o     (timeout_err)
    );

    assign ctl = {if_stall, id_stall, id_ex_valid, if_id_flush, ex_mem_hold};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge, settle, then return.
    task automatic drv(input logic [4:0] ra, input logic [4:0] rb,
                       input logic ura, input logic urb,
                       input logic [4:0] erd, input logic eld, input logic ewr,
                       input logic br, input logic req, input logic ack);
        @(negedge clk);
        rst_n           = rst_v;
        id_ra_addr      = ra;
        id_rb_addr      = rb;
        id_uses_ra      = ura;
        id_uses_rb      = urb;
        ex_rd_addr      = erd;
        ex_is_load      = eld;
        ex_writes_rd    = ewr;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ack         = ack;
        #1;
    endtask

    task automatic idle();
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_v        = 1'b0;
        rst_n        = 1'b0;
        id_ra_addr = 5'd0; id_rb_addr = 5'd0; ex_rd_addr = 5'd0;
        id_uses_ra = 1'b0; id_uses_rb = 1'b0; ex_is_load = 1'b0;
        ex_writes_rd = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

        // Reset with branch, load-use and mem wait all asserted: RUN outputs only.
        for (int i = 0; i < 2; i++) begin
            drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            check_eq("rst_ctl", {3'd0, ctl}, {3'd0, C_RUN});
            check_eq("rst_fwd", {4'd0, fwd_a_sel, fwd_b_sel}, 8'd0);
            check_eq("rst_err", {7'd0, timeout_err}, 8'd0);
        end
        rst_v = 1'b1;
        idle();
        check_eq("post_rst_ctl", {3'd0, ctl}, {3'd0, C_RUN});

        // ALU writes r5, then ID reads r5 twice: MEM then WB forwarding.
        drv(5'd7, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("alu_fwd_none", {6'd0, fwd_a_sel}, 8'd0);
        drv(5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("fwd_a_mem", {6'd0, fwd_a_sel}, 8'd1);
        check_eq("fwd_b_mem", {6'd0, fwd_b_sel}, 8'd1);
        drv(5'd5, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("fwd_a_wb", {6'd0, fwd_a_sel}, 8'd2);
        check_eq("fwd_b_nomatch", {6'd0, fwd_b_sel}, 8'd0);
        // Load to x0 read by ID: no stall, never forwarded.
        drv(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("x0_no_stall", {3'd0, ctl}, {3'd0, C_RUN});
        drv(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("x0_fwd_mem", {6'd0, fwd_a_sel}, 8'd0);
        drv(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("x0_fwd_wb", {6'd0, fwd_a_sel}, 8'd0);
        idle();
        idle();

        // Load r3 in EX, ID reads r3: one bubble, load-use inputs ignored in
        // LOAD_STALL, then WB forwarding of the load result.
        drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("lu_stall", {3'd0, ctl}, {3'd0, C_LU});
        drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("lu_stall_cycle", {3'd0, ctl}, {3'd0, C_RUN});
        check_eq("lu_no_mem_fwd", {6'd0, fwd_a_sel}, 8'd0);
        drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("lu_run", {3'd0, ctl}, {3'd0, C_RUN});
        check_eq("lu_fwd_wb", {6'd0, fwd_a_sel}, 8'd2);
        idle();
        idle();

        // Taken branch, penalty 2: exactly two flush cycles.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("br_flush0", {3'd0, ctl}, {3'd0, C_BR});
        idle();
        check_eq("br_flush1", {3'd0, ctl}, {3'd0, C_BR});
        idle();
        check_eq("br_done", {3'd0, ctl}, {3'd0, C_RUN});
        // Branch beats load-use; BR_FLUSH ignores load-use.
        drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("br_over_lu", {3'd0, ctl}, {3'd0, C_BR});
        drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("br_flush_lu", {3'd0, ctl}, {3'd0, C_BR});
        idle();
        check_eq("br_lu_done", {3'd0, ctl}, {3'd0, C_RUN});
        idle();

        // Memory wait of four cycles; tracker frozen while held.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drv(5'd9, 5'd10, 1'b1, 1'b1, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            check_eq($sformatf("mw_hold%0d", i), {3'd0, ctl}, {3'd0, C_MW});
        end
        check_eq("mw_frozen_fwd", {6'd0, fwd_a_sel}, 8'd1);
        drv(5'd9, 5'd10, 1'b1, 1'b1, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("mw_ack", {3'd0, ctl}, {3'd0, C_RUN});
        drv(5'd9, 5'd10, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("mw_resume", {3'd0, ctl}, {3'd0, C_RUN});
        check_eq("mw_fwd_a_wb", {6'd0, fwd_a_sel}, 8'd2);
        check_eq("mw_fwd_b_mem", {6'd0, fwd_b_sel}, 8'd1);
        // Request acked in the same cycle: no wait, state stays RUN.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("req_ack_same", {3'd0, ctl}, {3'd0, C_RUN});
        drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("req_ack_still_run", {3'd0, ctl}, {3'd0, C_LU});
        idle();
        idle();

        // Branch + load-use + mem wait together: wait first, then flush.
        for (int i = 0; i < 2; i++) begin
            drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            check_eq($sformatf("all3_wait%0d", i), {3'd0, ctl}, {3'd0, C_MW});
        end
        drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("all3_ack", {3'd0, ctl}, {3'd0, C_RUN});
        drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("all3_flush0", {3'd0, ctl}, {3'd0, C_BR});
        drv(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("all3_flush1", {3'd0, ctl}, {3'd0, C_BR});
        idle();
        check_eq("all3_done", {3'd0, ctl}, {3'd0, C_RUN});

        // Mem wait during BR_FLUSH resumes the flush with its saved count.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("brmw_flush0", {3'd0, ctl}, {3'd0, C_BR});
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("brmw_hold", {3'd0, ctl}, {3'd0, C_MW});
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("brmw_ack_hold", {7'd0, ex_mem_hold}, 8'd0);
        idle();
        check_eq("brmw_flush1", {3'd0, ctl}, {3'd0, C_BR});
        idle();
        check_eq("brmw_done", {3'd0, ctl}, {3'd0, C_RUN});

        // Memory never acks: error sets after 255 cycles in MEM_WAIT.
        for (int c = 0; c <= 256; c++) begin
            drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (c == 255) begin
                check_eq("tmo_not_yet", {7'd0, timeout_err}, 8'd0);
                check_eq("tmo_hold", {7'd0, ex_mem_hold}, 8'd1);
            end
            if (c == 256) begin
                check_eq("tmo_set", {7'd0, timeout_err}, 8'd1);
                check_eq("tmo_rewait", {3'd0, ctl}, {3'd0, C_MW});
            end
        end
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("tmo_ack", {3'd0, ctl}, {3'd0, C_RUN});
        idle();
        check_eq("tmo_sticky", {7'd0, timeout_err}, 8'd1);

        // Reset in the middle of BR_FLUSH aborts to RUN and clears the error.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("rbr_flush0", {3'd0, ctl}, {3'd0, C_BR});
        rst_v = 1'b0;
        idle();
        check_eq("rbr_in_rst", {3'd0, ctl}, {3'd0, C_RUN});
        rst_v = 1'b1;
        idle();
        check_eq("rbr_after", {3'd0, ctl}, {3'd0, C_RUN});
        check_eq("rbr_err_clr", {7'd0, timeout_err}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
